// File: rtl/master_axi_read_arbiter_if.sv
// Request/grant and AXI read-control handshakes between the read arbiter and its
// surroundings. The master modport is the arbiter's view.
interface master_axi_read_arbiter_if #(
    parameter int unsigned REQUESTER_COUNT  = 4,
    parameter int unsigned BEAT_COUNT_WIDTH = 9
);
    logic [REQUESTER_COUNT-1:0]  request;
    logic [REQUESTER_COUNT-1:0]  grant;
    logic [REQUESTER_COUNT-1:0]  done;
    logic                        ar_control_enable;
    logic                        ar_control_done;
    logic                        r_control_enable;
    logic                        r_control_done;
    logic                        r_control_last;
    logic [BEAT_COUNT_WIDTH-1:0] beat_count;
    logic                        beat_overflow;

    modport master (
        input  request, ar_control_done, r_control_done, r_control_last,
        output grant, done, ar_control_enable, r_control_enable, beat_count, beat_overflow
    );

    modport slave (
        output request, ar_control_done, r_control_done, r_control_last,
        input  grant, done, ar_control_enable, r_control_enable, beat_count, beat_overflow
    );
endinterface

// File: rtl/master_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel: grants a requester, runs its
// address phase, then counts data beats until RLAST and releases the channel.
module master_axi_read_arbiter #(
    parameter int unsigned REQUESTER_COUNT  = 4,
    parameter int unsigned BEAT_COUNT_WIDTH = 9
) (
    input logic                      clock,
    input logic                      reset_n,
    master_axi_read_arbiter_if.master bus
);
    localparam int unsigned IdxW = $clog2(REQUESTER_COUNT);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                      state_q, state_d;
    logic [REQUESTER_COUNT-1:0]  grant_q, grant_d;
    logic [REQUESTER_COUNT-1:0]  done_q, done_d;
    logic [IdxW-1:0]             ptr_q, ptr_d;
    logic [BEAT_COUNT_WIDTH-1:0] beat_q, beat_d;
    logic                        ovf_q, ovf_d;

    logic            sel_found;
    logic [IdxW-1:0] sel_idx;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] owner_idx;

    // First requesting index strictly after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int unsigned k = 1; k <= REQUESTER_COUNT; k++) begin
            cand = IdxW'((int'(ptr_q) + int'(k)) % int'(REQUESTER_COUNT));
            if (!sel_found && bus.request[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < REQUESTER_COUNT; i++) begin
            if (grant_q[i]) owner_idx = IdxW'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= IdxW'(REQUESTER_COUNT - 1);
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StAddr;
                    grant_d = REQUESTER_COUNT'(1) << sel_idx;
                    beat_d  = '0;
                end
            end
            StAddr: begin
                if (bus.ar_control_done) state_d = StData;
            end
            StData: begin
                if (bus.r_control_done) begin
                    // A beat arriving with the counter already full is lost.
                    if (beat_q == '1) ovf_d = 1'b1;
                    else              beat_d = beat_q + BEAT_COUNT_WIDTH'(1);
                    if (bus.r_control_last) begin
                        state_d = StIdle;
                        grant_d = '0;
                        done_d  = grant_q;
                        ptr_d   = owner_idx;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ar_control_enable = (state_q == StAddr);
        bus.r_control_enable  = (state_q == StData);
        bus.grant             = grant_q;
        bus.done              = done_q;
        bus.beat_count        = beat_q;
        bus.beat_overflow     = ovf_q;
    end
endmodule

// File: tb/tb_master_axi_read_arbiter.sv
// Randomized and directed bench for the AXI read arbiter against a transaction-level
// round-robin reference model.
module tb_master_axi_read_arbiter;
    localparam int RC = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    master_axi_read_arbiter_if #(.REQUESTER_COUNT(4), .BEAT_COUNT_WIDTH(9)) bus ();
    master_axi_read_arbiter_if #(.REQUESTER_COUNT(4), .BEAT_COUNT_WIDTH(3)) bus3 ();

    master_axi_read_arbiter #(.REQUESTER_COUNT(4), .BEAT_COUNT_WIDTH(9)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );
    master_axi_read_arbiter #(.REQUESTER_COUNT(4), .BEAT_COUNT_WIDTH(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int last_owner = RC - 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference arbitration: first requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [3:0] m, input int last);
        for (int k = 1; k <= RC; k++) begin
            int c;
            c = (last + k) % RC;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Drives one complete transaction and reports what the channel looked like.
    task automatic txn(input logic [3:0] req, input int ar_wait, input int nbeats,
                       input int gap, input bit noise, input bit drop,
                       output logic [3:0] g0, output int viol, output logic [3:0] done_end,
                       output logic [3:0] grant_end, output logic [8:0] beats_end);
        int bs;
        viol = 0;
        bs = 0;
        bus.request = req;
        tick();
        g0 = bus.grant;
        for (int i = 0; i < ar_wait; i++) begin
            if (bus.grant !== g0 || bus.ar_control_enable !== 1'b1 ||
                bus.r_control_enable !== 1'b0 || bus.done !== 4'b0) viol++;
            bus.r_control_done = noise;
            bus.r_control_last = noise;
            tick();
        end
        if (bus.grant !== g0 || bus.ar_control_enable !== 1'b1 ||
            bus.r_control_enable !== 1'b0 || bus.done !== 4'b0) viol++;
        bus.r_control_done  = 1'b0;
        bus.r_control_last  = 1'b0;
        bus.ar_control_done = 1'b1;
        tick();
        bus.ar_control_done = 1'b0;
        if (drop) bus.request = req & ~g0;
        for (int b = 1; b <= nbeats; b++) begin
            for (int j = 0; j < gap; j++) begin
                if (bus.grant !== g0 || bus.ar_control_enable !== 1'b0 ||
                    bus.r_control_enable !== 1'b1 || bus.done !== 4'b0 ||
                    bus.beat_count !== 9'(bs)) viol++;
                bus.r_control_done  = 1'b0;
                bus.r_control_last  = noise;
                bus.ar_control_done = noise;
                tick();
            end
            if (bus.grant !== g0 || bus.ar_control_enable !== 1'b0 ||
                bus.r_control_enable !== 1'b1 || bus.done !== 4'b0 ||
                bus.beat_count !== 9'(bs)) viol++;
            bus.ar_control_done = 1'b0;
            bus.r_control_done  = 1'b1;
            bus.r_control_last  = (b == nbeats);
            tick();
            bs++;
        end
        bus.r_control_done  = 1'b0;
        bus.r_control_last  = 1'b0;
        bus.ar_control_done = 1'b0;
        done_end  = bus.done;
        grant_end = bus.grant;
        beats_end = bus.beat_count;
        if (bus.ar_control_enable !== 1'b0 || bus.r_control_enable !== 1'b0) viol++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++; if (bus.grant !== 4'b0) begin tests_failed++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
        tests_run++; if (bus.done !== 4'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0000", bus.done); end
        tests_run++; if (bus.ar_control_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_ar_en got %b want 0", bus.ar_control_enable); end
        tests_run++; if (bus.r_control_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_r_en got %b want 0", bus.r_control_enable); end
        tests_run++; if (bus.beat_count !== 9'd0) begin tests_failed++; $display("FAIL reset_beats got %0d want 0", bus.beat_count); end
        tests_run++; if (bus.beat_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", bus.beat_overflow); end
        reset_n = 1'b1;
        tick();
        last_owner = RC - 1;
    endtask

    task automatic test_single_beat();
        logic [3:0] g, de, ge;
        logic [8:0] be;
        int v;
        txn(4'b0001, 1, 1, 1, 1'b0, 1'b0, g, v, de, ge, be);
        bus.request = 4'b0;
        tests_run++; if (g !== 4'b0001) begin tests_failed++; $display("FAIL single_grant got %b want 0001", g); end
        tests_run++; if (v !== 0) begin tests_failed++; $display("FAIL single_timing got %0d bad cycles want 0", v); end
        tests_run++; if (de !== 4'b0001) begin tests_failed++; $display("FAIL single_done got %b want 0001", de); end
        tests_run++; if (ge !== 4'b0000) begin tests_failed++; $display("FAIL single_release got %b want 0000", ge); end
        tests_run++; if (be !== 9'd1) begin tests_failed++; $display("FAIL single_beats got %0d want 1", be); end
        tick();
        tests_run++; if (bus.done !== 4'b0) begin tests_failed++; $display("FAIL single_done_pulse got %b want 0000", bus.done); end
        last_owner = 0;
    endtask

    task automatic test_round_robin();
        logic [3:0] g, de, ge;
        logic [8:0] be;
        logic [3:0] order [5];
        int v;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            txn(4'b1111, 0, 1, 0, 1'b0, 1'b0, g, v, de, ge, be);
            tests_run++; if (g !== order[n] || de !== order[n] || v !== 0) begin
                tests_failed++;
                $display("FAIL rr_order[%0d] got grant %b done %b viol %0d want %b", n, g, de, v, order[n]);
            end
        end
        bus.request = 4'b0;
        tick();
        last_owner = 0;
    endtask

    task automatic test_wrap();
        logic [3:0] g, de, ge;
        logic [8:0] be;
        int v;
        txn(4'b0010, 0, 1, 0, 1'b0, 1'b0, g, v, de, ge, be);
        tests_run++; if (g !== 4'b0010) begin tests_failed++; $display("FAIL wrap_first got %b want 0010", g); end
        txn(4'b0001, 0, 1, 0, 1'b0, 1'b0, g, v, de, ge, be);
        tests_run++; if (g !== 4'b0001 || de !== 4'b0001) begin tests_failed++; $display("FAIL wrap_grant got %b done %b want 0001", g, de); end
        bus.request = 4'b0;
        tick();
        last_owner = 0;
    endtask

    task automatic test_multi_beat();
        logic [3:0] g, de, ge;
        logic [8:0] be;
        int v;
        txn(4'b0100, 2, 4, 2, 1'b1, 1'b0, g, v, de, ge, be);
        bus.request = 4'b0;
        tests_run++; if (g !== 4'b0100) begin tests_failed++; $display("FAIL burst_grant got %b want 0100", g); end
        tests_run++; if (v !== 0) begin tests_failed++; $display("FAIL burst_protocol got %0d bad cycles want 0", v); end
        tests_run++; if (be !== 9'd4) begin tests_failed++; $display("FAIL burst_beats got %0d want 4", be); end
        tests_run++; if (de !== 4'b0100) begin tests_failed++; $display("FAIL burst_done got %b want 0100", de); end
        tick();
        tests_run++; if (bus.done !== 4'b0) begin tests_failed++; $display("FAIL burst_done_pulse got %b want 0000", bus.done); end
        last_owner = 2;
    endtask

    task automatic test_drop_request();
        logic [3:0] g, de, ge;
        logic [8:0] be;
        int v;
        txn(4'b1000, 1, 3, 1, 1'b0, 1'b1, g, v, de, ge, be);
        bus.request = 4'b0;
        tests_run++; if (g !== 4'b1000 || v !== 0) begin tests_failed++; $display("FAIL drop_burst got grant %b viol %0d want 1000/0", g, v); end
        tests_run++; if (de !== 4'b1000 || ge !== 4'b0) begin tests_failed++; $display("FAIL drop_done got done %b grant %b want 1000/0000", de, ge); end
        tick();
        last_owner = 3;
    endtask

    task automatic test_reset_mid_burst();
        bus.request = 4'b0010;
        tick();
        tests_run++; if (bus.grant !== onehot(rr_pick(4'b0010, last_owner))) begin tests_failed++; $display("FAIL midrst_grant got %b want 0010", bus.grant); end
        bus.ar_control_done = 1'b1;
        tick();
        bus.ar_control_done = 1'b0;
        bus.r_control_done = 1'b1;
        tick();
        bus.r_control_done = 1'b0;
        tests_run++; if (bus.r_control_enable !== 1'b1 || bus.beat_count !== 9'd1) begin
            tests_failed++; $display("FAIL midrst_data got r_en %b beats %0d want 1/1", bus.r_control_enable, bus.beat_count);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (bus.grant !== 4'b0 || bus.done !== 4'b0) begin tests_failed++; $display("FAIL midrst_clear got grant %b done %b want 0000", bus.grant, bus.done); end
        tests_run++; if (bus.ar_control_enable !== 1'b0 || bus.r_control_enable !== 1'b0 || bus.beat_count !== 9'd0) begin
            tests_failed++; $display("FAIL midrst_outputs got ar %b r %b beats %0d want 0", bus.ar_control_enable, bus.r_control_enable, bus.beat_count);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.request = 4'b1111;
        tests_run++; if (bus.done !== 4'b0) begin tests_failed++; $display("FAIL midrst_no_done got %b want 0000", bus.done); end
        tick();
        tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL midrst_regrant got %b want 0001", bus.grant); end
        bus.ar_control_done = 1'b1;
        tick();
        bus.ar_control_done = 1'b0;
        bus.request = 4'b0;
        bus.r_control_done = 1'b1;
        bus.r_control_last = 1'b1;
        tick();
        bus.r_control_done = 1'b0;
        bus.r_control_last = 1'b0;
        tests_run++; if (bus.done !== 4'b0001) begin tests_failed++; $display("FAIL midrst_finish got %b want 0001", bus.done); end
        last_owner = 0;
    endtask

    task automatic test_overflow();
        bus3.request = 4'b0001;
        tick();
        tests_run++; if (bus3.grant !== 4'b0001) begin tests_failed++; $display("FAIL ovf_grant got %b want 0001", bus3.grant); end
        bus3.ar_control_done = 1'b1;
        tick();
        bus3.ar_control_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus3.r_control_done = 1'b1;
            tick();
        end
        bus3.r_control_done = 1'b0;
        tests_run++; if (bus3.beat_count !== 3'd7) begin tests_failed++; $display("FAIL ovf_saturate got %0d want 7", bus3.beat_count); end
        tests_run++; if (bus3.beat_overflow !== 1'b1 || bus3.r_control_enable !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_flag got ovf %b r_en %b want 1/1", bus3.beat_overflow, bus3.r_control_enable);
        end
        bus3.r_control_done = 1'b1;
        bus3.r_control_last = 1'b1;
        tick();
        bus3.r_control_done = 1'b0;
        bus3.r_control_last = 1'b0;
        bus3.request = 4'b0;
        tests_run++; if (bus3.done !== 4'b0001 || bus3.grant !== 4'b0) begin tests_failed++; $display("FAIL ovf_end got done %b grant %b want 0001/0000", bus3.done, bus3.grant); end
        tick();
        tests_run++; if (bus3.beat_overflow !== 1'b1 || bus3.beat_count !== 3'd7) begin
            tests_failed++; $display("FAIL ovf_sticky got ovf %b beats %0d want 1/7", bus3.beat_overflow, bus3.beat_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] g, de, ge, mask;
        logic [8:0] be;
        int v, exp_owner, aw, nb, gp;
        bit nz, dr;
        for (int n = 0; n < 20; n++) begin
            mask = 4'($urandom_range(1, 15));
            aw = int'($urandom_range(0, 3));
            nb = int'($urandom_range(1, 6));
            gp = int'($urandom_range(0, 2));
            nz = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            exp_owner = rr_pick(mask, last_owner);
            txn(mask, aw, nb, gp, nz, dr, g, v, de, ge, be);
            tests_run++; if (g !== onehot(exp_owner)) begin tests_failed++; $display("FAIL rand[%0d]_grant mask %b got %b want %b", n, mask, g, onehot(exp_owner)); end
            tests_run++; if (v !== 0) begin tests_failed++; $display("FAIL rand[%0d]_protocol got %0d bad cycles want 0", n, v); end
            tests_run++; if (de !== onehot(exp_owner) || ge !== 4'b0) begin tests_failed++; $display("FAIL rand[%0d]_done got done %b grant %b want %b/0000", n, de, ge, onehot(exp_owner)); end
            tests_run++; if (be !== 9'(nb)) begin tests_failed++; $display("FAIL rand[%0d]_beats got %0d want %0d", n, be, nb); end
            last_owner = exp_owner;
        end
        bus.request = 4'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.request = '0;
        bus.ar_control_done = 1'b0;
        bus.r_control_done = 1'b0;
        bus.r_control_last = 1'b0;
        bus3.request = '0;
        bus3.ar_control_done = 1'b0;
        bus3.r_control_done = 1'b0;
        bus3.r_control_last = 1'b0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_wrap();
        test_multi_beat();
        test_drop_request();
        test_reset_mid_burst();
        test_overflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
